// File: rtl/int_to_fp_cvt.sv
// Signed 32-bit integer to IEEE-754 single converter, one normalising shift per cycle.
// Latency: 1 cycle for zero, leading_zeros(|x|)+2 otherwise; result held in DONE until out_ready.
module int_to_fp_cvt #(
    parameter int unsigned EXP_BIAS   = 127,
    parameter int unsigned ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] EXP_START = 8'(EXP_BIAS + 31);

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic [31:0] fp_q, fp_d;

    logic [31:0] abs_in;
    logic [22:0] frac;
    logic        guard, sticky, lsb, round_up;
    logic [30:0] rounded;

    // Two's-complement negate; 0x80000000 maps onto itself, which is the correct magnitude.
    assign abs_in   = int_in[31] ? (~int_in + 32'd1) : int_in;

    assign frac     = mag_q[30:8];
    assign guard    = mag_q[7];
    assign sticky   = |mag_q[6:0];
    assign lsb      = mag_q[8];
    assign round_up = (ROUND_MODE == 1) ? (guard & (sticky | lsb)) : 1'b0;
    // A carry out of the fraction ripples into the exponent field.
    assign rounded  = {exp_q, frac} + {30'd0, round_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            fp_q    <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            fp_q    <= fp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        fp_d    = fp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = int_in[31];
                    mag_d  = abs_in;
                    exp_d  = EXP_START;
                    if (int_in == 32'd0) begin
                        fp_d    = 32'd0;
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (!mag_q[31]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end else begin
                    fp_d    = {sign_q, rounded};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign fp_out    = fp_q;

endmodule
